data_mem_responder: RTL and testbench

//  Memory-side responder for the SingleCycleMIPS data-memory port.

---
 rtl/data_mem_responder_pkg.sv | 20 ++
 rtl/data_mem_responder_if.sv | 25 ++
 rtl/data_mem_responder_read_delay_line.sv | 48 ++++
 rtl/data_mem_responder.sv | 109 ++++++++++
 tb/tb_data_mem_responder.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared widths, read-latency bound and FSM state encoding for the data-memory responder.
package mem_if_pkg;

  localparam int ADDR_W       = 7;
  localparam int DATA_W       = 32;
  localparam int READ_LAT_MAX = 4;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Legal read latency is 1..READ_LAT_MAX; out-of-range values are clamped.
  function automatic int clamp_lat(input int lat);
    if (lat < 1) return 1;
    if (lat > READ_LAT_MAX) return READ_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU data-memory port: request signals from the core, read data and completion back.
interface data_mem_responder_if #(
  parameter int ADDR_W = mem_if_pkg::ADDR_W,
  parameter int DATA_W = mem_if_pkg::DATA_W
);

  logic              CEN;
  logic              WEN;
  logic              OEN;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] Data2Mem;
  logic [DATA_W-1:0] RDM;
  logic              rvalid;

  modport master (
    output CEN, WEN, OEN, A, Data2Mem,
    input  RDM, rvalid
  );

  modport slave (
    input  CEN, WEN, OEN, A, Data2Mem,
    output RDM, rvalid
  );

endinterface

// File: rtl/data_mem_responder_read_delay_line.sv
// Shift register of {valid, data} that sets the read latency; only the valids are reset.
module read_delay_line
  import mem_if_pkg::*;
#(
  parameter int DATA_W = mem_if_pkg::DATA_W,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_dat,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_dat
);

  logic [LAT-1:0]             vld_q;
  logic [LAT-1:0]             vld_d;
  logic [LAT-1:0][DATA_W-1:0] dat_q;
  logic [LAT-1:0][DATA_W-1:0] dat_d;

  always_comb begin
    vld_d    = vld_q;
    dat_d    = dat_q;
    vld_d[0] = in_vld;
    dat_d[0] = in_dat;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  // Data stages carry no reset; they are only observed behind their valid.
  always_ff @(posedge clk) begin
    dat_q <= dat_d;
  end

  assign out_vld = vld_q[LAT-1];
  assign out_dat = dat_q[LAT-1];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word array, power-up/clear FSM, request decode and OEN output gate.
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int ADDR_W   = mem_if_pkg::ADDR_W,
  parameter int DATA_W   = mem_if_pkg::DATA_W,
  parameter int DEPTH    = 2**ADDR_W,
  parameter int READ_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_req,
  output logic                  busy,
  data_mem_responder_if.slave   bus
);

  localparam int LAT = clamp_lat(READ_LAT);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_req;
  logic [DATA_W-1:0] rd_word;
  logic              pipe_vld;
  logic [DATA_W-1:0] pipe_dat;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // The clear walk owns the write port; requests are only decoded in ST_READY
  // and a clear request on the same edge takes priority over them.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_we    = 1'b0;
    mem_waddr = bus.A;
    mem_wdata = bus.Data2Mem;
    rd_req    = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (clear_req) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end else if (!bus.CEN) begin
          mem_we = !bus.WEN;
          rd_req = bus.WEN;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign rd_word = mem_q[bus.A];

  read_delay_line #(
    .DATA_W (DATA_W),
    .LAT    (LAT)
  ) u_read_delay_line (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (rd_req),
    .in_dat  (rd_word),
    .out_vld (pipe_vld),
    .out_dat (pipe_dat)
  );

  // rd_data follows a completing read on the edge it completes, then holds.
  always_comb begin
    rd_data_d = rd_data_q;
    if (pipe_vld) begin
      rd_data_d = pipe_dat;
    end
  end

  assign bus.rvalid = pipe_vld;
  assign bus.RDM    = bus.OEN ? '0 : rd_data_d;
  assign busy       = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_data_mem_responder.sv
// Drives identical traffic into READ_LAT=1 and READ_LAT=3 responders and scoreboards both.
module tb_data_mem_responder;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clear_req = 1'b0;
  logic        cen = 1'b1;
  logic        wen = 1'b1;
  logic        oen = 1'b0;
  logic [6:0]  a = '0;
  logic [31:0] d = '0;
  logic        busy1, busy3;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [128];
  exp_t        q1[$];
  exp_t        q3[$];

  data_mem_responder_if b1 ();
  data_mem_responder_if b3 ();

  assign b1.CEN = cen;
  assign b1.WEN = wen;
  assign b1.OEN = oen;
  assign b1.A = a;
  assign b1.Data2Mem = d;
  assign b3.CEN = cen;
  assign b3.WEN = wen;
  assign b3.OEN = oen;
  assign b3.A = a;
  assign b3.Data2Mem = d;

  data_mem_responder #(.READ_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy1), .bus(b1));
  data_mem_responder #(.READ_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy3), .bus(b3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitors: every cycle compare rvalid against the scoreboard head, and data on completion.
  always @(posedge clk) begin : mon1
    logic ev;
    #2;
    ev = (q1.size() > 0) && (q1[0].due == cyc);
    check("rvalid_lat1", {31'b0, b1.rvalid}, {31'b0, ev});
    if (ev) begin
      check("rdm_lat1", b1.RDM, oen ? 32'h0 : q1[0].data);
      void'(q1.pop_front());
    end
  end

  always @(posedge clk) begin : mon3
    logic ev;
    #2;
    ev = (q3.size() > 0) && (q3[0].due == cyc);
    check("rvalid_lat3", {31'b0, b3.rvalid}, {31'b0, ev});
    if (ev) begin
      check("rdm_lat3", b3.RDM, oen ? 32'h0 : q3[0].data);
      void'(q3.pop_front());
    end
  end

  task automatic do_write(input logic [6:0] addr, input logic [31:0] data, input bit acc);
    @(negedge clk);
    cen = 1'b0; wen = 1'b0; a = addr; d = data;
    if (acc) model[addr] = data;
  endtask

  task automatic do_read(input logic [6:0] addr, input bit acc);
    exp_t e;
    @(negedge clk);
    cen = 1'b0; wen = 1'b1; a = addr;
    if (acc) begin
      e.data = model[addr];
      e.due  = cyc + 1;
      q1.push_back(e);
      e.due  = cyc + 3;
      q3.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cen = 1'b1; wen = 1'b1;
    end
  endtask

  // Clear pulse, optionally with a write on the same edge; returns edge count at entry to clear.
  task automatic do_clear(input bit with_write, output int start);
    @(negedge clk);
    clear_req = 1'b1;
    if (with_write) begin
      cen = 1'b0; wen = 1'b0; a = 7'd10; d = 32'd7;
    end else begin
      cen = 1'b1; wen = 1'b1;
    end
    @(posedge clk);
    #2;
    clear_req = 1'b0; cen = 1'b1; wen = 1'b1;
    start = cyc;
    for (int i = 0; i < 128; i++) model[i] = '0;
    check("busy_after_clear_req", {31'b0, busy1}, 32'd1);
  endtask

  task automatic wait_idle(input string nm, input int start);
    do begin
      @(posedge clk);
      #2;
    end while ((busy1 || busy3) && (cyc - start) < 300);
    check(nm, cyc - start, 128);
    check({nm, "_busy3"}, {31'b0, busy3}, 32'd0);
  endtask

  initial begin : stim
    int start;
    for (int i = 0; i < 128; i++) model[i] = '0;
    #1 rst_n = 1'b0;
    #7;
    check("reset_busy1", {31'b0, busy1}, 32'd1);
    check("reset_busy3", {31'b0, busy3}, 32'd1);
    check("reset_rdm1", b1.RDM, 32'd0);
    check("reset_rdm3", b3.RDM, 32'd0);
    #4 rst_n = 1'b1;
    start = cyc;
    wait_idle("por_clear_edges", start);

    do_read(7'd5, 1'b1);
    idle(4);

    do_write(7'd10, 32'd19, 1'b1);
    do_read(7'd10, 1'b1);
    idle(4);

    @(negedge clk); oen = 1'b1; #1;
    check("oen_gate_rdm1", b1.RDM, 32'd0);
    check("oen_gate_rdm3", b3.RDM, 32'd0);
    @(negedge clk); oen = 1'b0; #1;
    check("oen_hold_rdm1", b1.RDM, 32'd19);
    check("oen_hold_rdm3", b3.RDM, 32'd19);

    do_write(7'd1, 32'd11, 1'b1);
    do_write(7'd2, 32'd22, 1'b1);
    do_write(7'd3, 32'd33, 1'b1);
    do_write(7'd127, 32'hDEADBEEF, 1'b1);
    do_write(7'd0, 32'hFFFFFFFF, 1'b1);
    do_read(7'd1, 1'b1);
    do_read(7'd2, 1'b1);
    do_read(7'd3, 1'b1);
    do_read(7'd127, 1'b1);
    do_read(7'd0, 1'b1);
    idle(5);

    do_write(7'd30, 32'h55, 1'b1);
    do_read(7'd30, 1'b1);
    do_clear(1'b1, start);
    do_read(7'd10, 1'b0);
    do_write(7'd20, 32'd5, 1'b0);
    do_read(7'd20, 1'b0);
    idle(1);
    wait_idle("req_clear_edges", start);
    do_read(7'd10, 1'b1);
    do_read(7'd20, 1'b1);
    do_read(7'd30, 1'b1);
    idle(4);

    do_clear(1'b0, start);
    repeat (50) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midclear_rst_busy1", {31'b0, busy1}, 32'd1);
    check("midclear_rst_busy3", {31'b0, busy3}, 32'd1);
    #12 rst_n = 1'b1;
    start = cyc;
    do_read(7'd1, 1'b0);
    idle(1);
    wait_idle("rst_clear_edges", start);
    do_read(7'd1, 1'b1);
    idle(5);

    check("queue1_drained", q1.size(), 32'd0);
    check("queue3_drained", q3.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #60000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
